// File: rtl/mmu_host_rd_demux.sv
// Host read data demux: queues {id,len} ordering entries and steers the single
// XDMA read stream to the owning region, regenerating tlast per entry.
module mmu_host_rd_demux #(
  parameter int N_ID       = 4,
  parameter int LEN_BITS   = 28,
  parameter int DATA_BITS  = 512,
  parameter int QDEPTH     = 8,
  localparam int ID_BITS   = (N_ID > 1) ? $clog2(N_ID) : 1,
  localparam int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_mux_valid,
  output logic                        s_mux_ready,
  input  logic [ID_BITS+LEN_BITS-1:0] s_mux_data,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_BITS-1:0]        s_axis_tdata,
  input  logic [KEEP_BITS-1:0]        s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic [N_ID-1:0]             m_axis_tvalid,
  input  logic [N_ID-1:0]             m_axis_tready,
  output logic [DATA_BITS-1:0]        m_axis_tdata,
  output logic [KEEP_BITS-1:0]        m_axis_tkeep,
  output logic                        m_axis_tlast
);

  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int PTR_BITS   = $clog2(QDEPTH);
  localparam int ENT_BITS   = ID_BITS + LEN_BITS;
  localparam logic [LEN_BITS:0] ROUND_UP = (LEN_BITS+1)'(BEAT_BYTES - 1);
  localparam logic [LEN_BITS:0] CNT_ONE  = (LEN_BITS+1)'(1);
  localparam logic [PTR_BITS:0] PTR_ONE  = (PTR_BITS+1)'(1);
  localparam logic [ID_BITS:0]  N_ID_W   = (ID_BITS+1)'(N_ID);

  typedef enum logic {IDLE, XFER} state_t;

  logic [ENT_BITS-1:0] fifo_mem [QDEPTH];
  logic [PTR_BITS:0]   wr_ptr_reg, rd_ptr_reg;
  logic                fifo_empty, fifo_full, push, pop, beat;
  logic [ENT_BITS-1:0] head;
  logic [ID_BITS-1:0]  head_id;
  logic [LEN_BITS-1:0] head_len;
  logic [LEN_BITS:0]   head_beats;
  state_t              state_reg, state_next;
  logic [ID_BITS-1:0]  cur_id_reg;
  logic [LEN_BITS:0]   cnt_reg;
  logic                id_in_range;
  logic [N_ID-1:0]     region_sel, region_rdy;
  logic                unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;

  // Ordering FIFO; the extra pointer bit distinguishes full from empty.
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full   = (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]) &&
                       (wr_ptr_reg[PTR_BITS-1:0] == rd_ptr_reg[PTR_BITS-1:0]);
  assign s_mux_ready = !fifo_full;
  assign push        = s_mux_valid && !fifo_full;

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_BITS-1:0]] <= s_mux_data;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Head decode; the extra bit keeps the round-up from overflowing.
  assign head       = fifo_mem[rd_ptr_reg[PTR_BITS-1:0]];
  assign head_id    = head[ENT_BITS-1:LEN_BITS];
  assign head_len   = head[LEN_BITS-1:0];
  assign head_beats = ({1'b0, head_len} + ROUND_UP) >> BEAT_SHIFT;

  assign id_in_range = ({1'b0, cur_id_reg} < N_ID_W);

  generate
    for (genvar gi = 0; gi < N_ID; gi++) begin : g_region
      assign region_sel[gi] = (cur_id_reg == ID_BITS'(gi));
      assign region_rdy[gi] = region_sel[gi] && m_axis_tready[gi];
    end
  endgenerate

  assign beat = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pop && (head_beats != '0)) state_next = XFER;
      XFER:    if (beat && (cnt_reg == '0))   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range ids drain their beats with every region valid held low.
  always_comb begin
    pop           = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = '0;
    m_axis_tlast  = 1'b0;
    case (state_reg)
      IDLE: pop = !fifo_empty;
      XFER: begin
        s_axis_tready = id_in_range ? |region_rdy : 1'b1;
        m_axis_tvalid = s_axis_tvalid ? region_sel : '0;
        m_axis_tlast  = (cnt_reg == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_id_reg <= '0;
      cnt_reg    <= '0;
    end else if (pop) begin
      cur_id_reg <= head_id;
      cnt_reg    <= head_beats - CNT_ONE;
    end else if (beat && (cnt_reg != '0)) begin
      cnt_reg    <= cnt_reg - CNT_ONE;
    end
  end

endmodule
